pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the IF stage of the in-order pipeline; the pipeline has no forwarding.
- Successor to the plain enable-gated PC register. Adds:
  - parametrised reset vector and instruction size
  - fixed-priority next-PC selection: trap, branch/jump redirect, stall, sequential
  - a pending-redirect slot, so a redirect that arrives during a stall is not lost
  - a flush counter that kills the wrong-path instructions already in flight
  - a misalignment flag

Parameters:
- WIDTH, 32: PC width in bits.
- RESET_VEC, 32'h0000_0000: PC value loaded on reset.
- INSTR_BYTES, 4: sequential increment; a power of two, 2 or 4.
- FLUSH_CYCLES, 2: number of cycles kill_o stays high after a redirect or trap; range 1..7.
- HIST_DEPTH, 4: entries in the optional redirect history; a power of two.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- stall_i  in  1  hazard/imem stall; holds the PC.
- redirect_valid_i  in  1  branch/jump resolved taken in EX; single-cycle pulse.
- redirect_pc_i  in  WIDTH  redirect target.
- trap_valid_i  in  1  exception/interrupt request; single-cycle pulse.
- trap_vec_i  in  WIDTH  trap handler address.
- current_pc_o  out  WIDTH  fetch address.
- pc_valid_o  out  1  current_pc_o is a valid fetch address.
- pc_plus_o  out  WIDTH  current_pc_o + INSTR_BYTES, combinational; used as the link value.
- kill_o  out  1  squash the IF/ID and ID/EX contents.
- misalign_o  out  1  one-cycle flag: the applied target had nonzero low bits.
- pc_debug_o  out  WIDTH  mirror of current_pc_o.
- hist_idx_i  in  $clog2(HIST_DEPTH)  history read index; 0 = newest.
- hist_pc_o  out  WIDTH  history read data.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: current_pc_o=RESET_VEC, pc_valid_o=0, kill_o=0, misalign_o=0. The pending slot and history are cleared, and the FSM enters BOOT.
- FSM states:
  - BOOT: entered on reset. pc_valid_o=0, PC holds. Goes to RUN on the next clock with rst_i=0.
  - RUN: pc_valid_o=1.
  - PEND: pc_valid_o=1 and the PC holds. A latched redirect (pend_pc) is waiting.
- Next-PC priority, evaluated every clock in RUN/PEND, highest first:
  1. rst_i
  2. trap_valid_i: PC <= trap_vec_i. Applied even when stalled. Clears PEND and goes to RUN.
  3. redirect_valid_i with stall_i=0: PC <= redirect_pc_i.
  4. redirect_valid_i with stall_i=1: pend_pc <= redirect_pc_i, go to PEND, PC holds. A newer redirect arriving in PEND overwrites pend_pc.
  5. In PEND with stall_i=0: PC <= pend_pc, go to RUN.
  6. stall_i=1: PC holds.
  7. Otherwise: PC <= PC + INSTR_BYTES, modulo 2^WIDTH (0xFFFFFFFC wraps to 0x0).
- Target alignment:
  - Every applied target (trap, redirect, pend_pc) has its low log2(INSTR_BYTES) bits forced to 0.
  - misalign_o=1 on the cycle after the load if any of those bits were 1.
- Kill counter:
  - Loaded with FLUSH_CYCLES on the clock edge where a trap, redirect or pend_pc is applied to the PC.
  - kill_o = (counter != 0). The counter decrements each clock and does not decrement while stall_i=1.
  - A new application while the counter is nonzero reloads it.
  - A redirect that is only latched into PEND does not load the counter.
- Simultaneous trap and redirect: the trap wins and the redirect is dropped.
- Reset mid-PEND or mid-kill: all state is cleared on that edge.
- Latency: one clock from input to current_pc_o. pc_plus_o is zero-latency.

Optional Feature:
- Macro: PC_GEN_HIST_EN.
- Defined:
  - A HIST_DEPTH circular buffer records the PC value that was replaced on each applied trap or redirect (the source PC).
  - hist_pc_o = entry hist_idx_i, where 0 = newest. Entries never written read 0.
  - The buffer is cleared by rst_i.
- Undefined:
  - No buffer storage is generated.
  - hist_pc_o is tied to 0 and hist_idx_i is ignored. Port list is unchanged.

Decomposition:
- Package pc_gen_pkg holds:
  - typedef enum logic [1:0] {BOOT, RUN, PEND} pc_state_e
  - typedef struct {valid, pc} redirect_t
  - localparam function for the alignment mask
- One sub-module: pc_gen_hist, the history ring buffer, instantiated only under PC_GEN_HIST_EN.

Test Plan:
- Reset and boot (RESET_VEC=0x100): hold rst_i for 2 clocks, then release.
  - pc_valid_o=0 for the first cycle after release, then 1.
  - PC runs 0x100, 0x104, 0x108.
- Sequential run with stall: PC=0x200, stall_i=1 for 3 clocks.
  - PC stays 0x200 for 3 clocks, then 0x204.
- Redirect during stall: PC=0x300, stall_i=1, redirect to 0x500, stall held 2 more clocks.
  - PC holds at 0x300 in PEND.
  - PC=0x500 one clock after stall_i falls.
  - kill_o high for 2 clocks after that.
- Trap beats redirect and stall: stall_i=1, redirect 0x600 and trap to 0x80 on the same cycle.
  - Next PC=0x80, pend_pc discarded, kill_o reloaded to 2.
- Misaligned target and wrap: redirect to 0x403.
  - PC=0x400 and misalign_o pulses once.
  - PC=0xFFFFFFFC with no stall gives next PC=0x0.
- History (PC_GEN_HIST_EN): apply 5 redirects from PCs A..E with HIST_DEPTH=4.
  - hist_idx_i=0 returns E and hist_idx_i=3 returns B.
  - After rst_i every index returns 0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the IF-stage program-counter generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  // Widest PC the pending-redirect slot can carry; narrower PCs are zero-extended.
  localparam int unsigned PC_MAX_W = 64;

  typedef struct packed {
    logic                valid;
    logic [PC_MAX_W-1:0] pc;
  } redirect_t;

  function automatic logic [PC_MAX_W-1:0] align_mask(input int unsigned instr_bytes);
    return PC_MAX_W'(instr_bytes - 32'd1);
  endfunction

endpackage

// File: rtl/pc_gen_hist.sv
// Ring buffer of the PCs replaced by applied traps/redirects; index 0 reads the newest entry.
module pc_gen_hist #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_pc_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [WIDTH-1:0]         rd_pc_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] wr_ptr_q;
  logic [IDX_W-1:0] rd_ptr_s;

  // Entries are cleared on reset so never-written slots read as zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_pc_i;
      wr_ptr_q        <= wr_ptr_q + IDX_W'(1);
    end
  end

  // DEPTH is a power of two, so the pointer arithmetic wraps naturally.
  assign rd_ptr_s = wr_ptr_q - rd_idx_i - IDX_W'(1);
  assign rd_pc_o  = mem_q[rd_ptr_s];

endmodule

// File: rtl/pc_gen.sv
// IF-stage PC generator: trap > redirect > pending redirect > stall > sequential, with flush counter.
// Optional redirect history ring buffer enabled by defining PC_GEN_HIST_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC    = '0,
  parameter int unsigned       INSTR_BYTES  = 4,
  parameter int unsigned       FLUSH_CYCLES = 2,
  parameter int unsigned       HIST_DEPTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          stall_i,
  input  logic                          redirect_valid_i,
  input  logic [WIDTH-1:0]              redirect_pc_i,
  input  logic                          trap_valid_i,
  input  logic [WIDTH-1:0]              trap_vec_i,
  output logic [WIDTH-1:0]              current_pc_o,
  output logic                          pc_valid_o,
  output logic [WIDTH-1:0]              pc_plus_o,
  output logic                          kill_o,
  output logic                          misalign_o,
  output logic [WIDTH-1:0]              pc_debug_o,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx_i,
  output logic [WIDTH-1:0]              hist_pc_o
);

  localparam logic [WIDTH-1:0] LOW_MASK  = WIDTH'(align_mask(INSTR_BYTES));
  localparam logic [WIDTH-1:0] INC       = WIDTH'(INSTR_BYTES);
  localparam logic [2:0]       KILL_LOAD = 3'(FLUSH_CYCLES);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  redirect_t        pend_q, pend_d;
  logic [2:0]       kill_q, kill_d;
  logic             misalign_q, misalign_d;
  logic             valid_q, valid_d;
  logic             apply_s;
  logic [WIDTH-1:0] target_s;

  // Next-state selection; any applied target also reloads the flush counter.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    misalign_d = 1'b0;
    apply_s    = 1'b0;
    target_s   = '0;
    if ((kill_q != 3'd0) && !stall_i) begin
      kill_d = kill_q - 3'd1;
    end else begin
      kill_d = kill_q;
    end
    case (state_q)
      BOOT: state_d = RUN;
      RUN, PEND: begin
        if (trap_valid_i) begin
          apply_s  = 1'b1;
          target_s = trap_vec_i;
        end else if (redirect_valid_i && !stall_i) begin
          apply_s  = 1'b1;
          target_s = redirect_pc_i;
        end else if (redirect_valid_i) begin
          pend_d.valid = 1'b1;
          pend_d.pc    = PC_MAX_W'(redirect_pc_i);
          state_d      = PEND;
        end else if (pend_q.valid && !stall_i) begin
          apply_s  = 1'b1;
          target_s = WIDTH'(pend_q.pc);
        end else if (stall_i) begin
          pc_d = pc_q;
        end else begin
          pc_d = pc_q + INC;
        end
      end
      default: state_d = BOOT;
    endcase
    if (apply_s) begin
      pc_d       = target_s & ~LOW_MASK;
      misalign_d = |(target_s & LOW_MASK);
      kill_d     = KILL_LOAD;
      pend_d     = '0;
      state_d    = RUN;
    end else begin
      misalign_d = 1'b0;
    end
    valid_d = (state_d != BOOT);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pend_q     <= '0;
      kill_q     <= 3'd0;
      misalign_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      kill_q     <= kill_d;
      misalign_q <= misalign_d;
      valid_q    <= valid_d;
    end
  end

  assign current_pc_o = pc_q;
  assign pc_debug_o   = pc_q;
  assign pc_plus_o    = pc_q + INC;
  assign pc_valid_o   = valid_q;
  assign kill_o       = (kill_q != 3'd0);
  assign misalign_o   = misalign_q;

`ifdef PC_GEN_HIST_EN
  pc_gen_hist #(
    .WIDTH (WIDTH),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (apply_s),
    .wr_pc_i  (pc_q),
    .rd_idx_i (hist_idx_i),
    .rd_pc_o  (hist_pc_o)
  );
`else
  logic unused_hist_s;
  assign unused_hist_s = ^hist_idx_i;
  assign hist_pc_o     = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a reference model.
module tb_pc_gen;

  localparam int          IB = 4;
  localparam int          FC = 2;
  localparam int          HD = 4;
  localparam int          IW = $clog2(HD);
  localparam logic [31:0] RV = 32'h0000_0100;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1, stall_i = 1'b0, redirect_valid_i = 1'b0, trap_valid_i = 1'b0;
  logic [31:0]   redirect_pc_i = 32'h0, trap_vec_i = 32'h0;
  logic [IW-1:0] hist_idx_i = '0;
  logic [31:0]   current_pc_o, pc_plus_o, pc_debug_o, hist_pc_o;
  logic          pc_valid_o, kill_o, misalign_o;

  int checks = 0;
  int failures = 0;

  // Reference model state, written from the behavioural rules.
  logic [31:0] m_pc = RV;
  bit          m_valid = 1'b0, m_boot = 1'b1, m_pend_v = 1'b0, m_mis = 1'b0;
  logic [31:0] m_pend_pc = 32'h0;
  int          m_kill = 0;
  logic [31:0] m_hist[$];

  pc_gen #(
    .WIDTH(32), .RESET_VEC(RV), .INSTR_BYTES(IB), .FLUSH_CYCLES(FC), .HIST_DEPTH(HD)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .trap_valid_i(trap_valid_i), .trap_vec_i(trap_vec_i),
    .current_pc_o(current_pc_o), .pc_valid_o(pc_valid_o), .pc_plus_o(pc_plus_o),
    .kill_o(kill_o), .misalign_o(misalign_o), .pc_debug_o(pc_debug_o),
    .hist_idx_i(hist_idx_i), .hist_pc_o(hist_pc_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] m_hist_at(input int idx);
`ifdef PC_GEN_HIST_EN
    if (idx < m_hist.size()) return m_hist[idx];
`endif
    return 32'h0;
  endfunction

  // Drive one cycle of inputs, clock it, advance the model, and settle 1 time unit past the edge.
  task automatic step(input bit rst, input bit st, input bit rv, input logic [31:0] rpc,
                      input bit tv, input logic [31:0] tvec);
    bit          applied;
    logic [31:0] tgt;
    rst_i = rst; stall_i = st; redirect_valid_i = rv; redirect_pc_i = rpc;
    trap_valid_i = tv; trap_vec_i = tvec; hist_idx_i = IW'($urandom_range(HD - 1));
    @(posedge clk_i);
    applied = 1'b0;
    tgt     = 32'h0;
    if (rst) begin
      m_pc = RV; m_valid = 1'b0; m_boot = 1'b1; m_pend_v = 1'b0; m_kill = 0; m_mis = 1'b0;
      m_hist.delete();
    end else if (m_boot) begin
      m_boot = 1'b0; m_valid = 1'b1; m_mis = 1'b0;
    end else begin
      if (tv) begin
        applied = 1'b1; tgt = tvec; m_pend_v = 1'b0;
      end else if (rv && !st) begin
        applied = 1'b1; tgt = rpc; m_pend_v = 1'b0;
      end else if (rv) begin
        m_pend_v = 1'b1; m_pend_pc = rpc;
      end else if (m_pend_v && !st) begin
        applied = 1'b1; tgt = m_pend_pc; m_pend_v = 1'b0;
      end else if (!st) begin
        m_pc = m_pc + 32'(IB);  // 32-bit arithmetic gives the modulo-2^32 wrap
      end
      if (applied) m_kill = FC;
      else if (!st && m_kill > 0) m_kill = m_kill - 1;
      m_mis = applied && ((tgt % IB) != 0);
      if (applied) begin
        m_hist.push_front(m_pc);
        if (m_hist.size() > HD) void'(m_hist.pop_back());
        m_pc = tgt - (tgt % IB);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_pc = (i < 2) ? 32'h100 : 32'h100 + 32'(4 * (i - 1));
      checks++;
      if ({current_pc_o, pc_valid_o, kill_o, misalign_o} !== {exp_pc, (i != 0), 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_boot[%0d]: got pc=%h valid=%b kill=%b mis=%b, want pc=%h valid=%b kill=0 mis=0",
                 i, current_pc_o, pc_valid_o, kill_o, misalign_o, exp_pc, (i != 0));
      end
      if (i < 3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      exp_pc = (i < 4) ? 32'h200 : 32'h204;
      checks++;
      if (current_pc_o !== exp_pc || kill_o !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got pc=%h kill=%b, want pc=%h kill=1", i, current_pc_o, kill_o, exp_pc);
      end
      if (i < 4) step(1'b0, (i < 3), 1'b0, 32'h0, 1'b0, 32'h0);
    end
  endtask

  task automatic test_redirect_in_stall();
    logic [31:0] exp_pc;
    logic        exp_kill;
    step(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      exp_pc   = (i < 3) ? 32'h300 : 32'h500 + 32'(4 * (i - 3));
      exp_kill = (i != 5);
      checks++;
      if (current_pc_o !== exp_pc || kill_o !== exp_kill || pc_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL redirect_pend[%0d]: got pc=%h kill=%b valid=%b, want pc=%h kill=%b valid=1",
                 i, current_pc_o, kill_o, pc_valid_o, exp_pc, exp_kill);
      end
      if (i < 5) step(1'b0, (i < 2), 1'b0, 32'h0, 1'b0, 32'h0);
    end
  endtask

  task automatic test_trap_priority();
    logic [31:0] exp_pc [4] = '{32'h80, 32'h80, 32'h84, 32'h88};
    logic        exp_kill [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    step(1'b0, 1'b0, 1'b1, 32'h650, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h600, 1'b1, 32'h80);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (current_pc_o !== exp_pc[i] || kill_o !== exp_kill[i]) begin
        failures++;
        $display("FAIL trap_priority[%0d]: got pc=%h kill=%b, want pc=%h kill=%b",
                 i, current_pc_o, kill_o, exp_pc[i], exp_kill[i]);
      end
      if (i < 3) step(1'b0, (i == 0), 1'b0, 32'h0, 1'b0, 32'h0);
    end
  endtask

  task automatic test_misalign_wrap();
    logic [31:0] exp_pc [4] = '{32'h400, 32'h404, 32'hFFFF_FFFC, 32'h0};
    logic        exp_mis [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] exp_plus;
    step(1'b0, 1'b0, 1'b1, 32'h403, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_plus = (i == 2) ? 32'h0 : exp_pc[i] + 32'h4;
      checks++;
      if (current_pc_o !== exp_pc[i] || misalign_o !== exp_mis[i] || pc_plus_o !== exp_plus) begin
        failures++;
        $display("FAIL misalign_wrap[%0d]: got pc=%h mis=%b plus=%h, want pc=%h mis=%b plus=%h",
                 i, current_pc_o, misalign_o, pc_plus_o, exp_pc[i], exp_mis[i], exp_plus);
      end
      if (i == 1) step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      else if (i < 3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    end
  endtask

  task automatic test_history();
`ifdef PC_GEN_HIST_EN
    logic [31:0] exp_h [4] = '{32'h4004, 32'h3004, 32'h2004, 32'h1004};
`else
    logic [31:0] exp_h [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    hist_idx_i = '0;
    #1;
    checks++;
    if (hist_pc_o !== 32'h0) begin
      failures++;
      $display("FAIL hist_empty: got %h, want 00000000", hist_pc_o);
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 32'(32'h1000 * (k + 1)), 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    end
    for (int i = 0; i < HD; i++) begin
      hist_idx_i = IW'(i);
      #1;
      checks++;
      if (hist_pc_o !== exp_h[i]) begin
        failures++;
        $display("FAIL hist_read[%0d]: got %h, want %h", i, hist_pc_o, exp_h[i]);
      end
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < HD; i++) begin
      hist_idx_i = IW'(i);
      #1;
      checks++;
      if (hist_pc_o !== 32'h0) begin
        failures++;
        $display("FAIL hist_cleared[%0d]: got %h, want 00000000", i, hist_pc_o);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(99) == 0, $urandom_range(2) == 0, $urandom_range(5) == 0, $urandom,
           $urandom_range(19) == 0, $urandom);
      checks++;
      if ({current_pc_o, pc_valid_o, kill_o, misalign_o} !== {m_pc, m_valid, (m_kill != 0), m_mis}) begin
        failures++;
        $display("FAIL random_state[%0d]: got pc=%h valid=%b kill=%b mis=%b, want pc=%h valid=%b kill=%b mis=%b",
                 n, current_pc_o, pc_valid_o, kill_o, misalign_o, m_pc, m_valid, (m_kill != 0), m_mis);
      end
      checks++;
      if (pc_plus_o !== m_pc + 32'(IB) || pc_debug_o !== m_pc || hist_pc_o !== m_hist_at(int'(hist_idx_i))) begin
        failures++;
        $display("FAIL random_aux[%0d]: got plus=%h dbg=%h hist=%h, want plus=%h dbg=%h hist=%h",
                 n, pc_plus_o, pc_debug_o, hist_pc_o, m_pc + 32'(IB), m_pc, m_hist_at(int'(hist_idx_i)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_in_stall();
    test_trap_priority();
    test_misalign_wrap();
    test_history();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
